// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and arbiter state encoding.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b111;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the pipeline stages (master) and the ALU arbiter (slave).
interface alu_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*32-1:0]   req_src_a;
   logic [NREQ*32-1:0]   req_src_b;
   logic [NREQ*3-1:0]    req_op;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [31:0]          rsp_result;
   logic [3:0]           rsp_flags;
   logic                 busy;

   modport master (
      output req_valid, req_src_a, req_src_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flags, busy
   );

   modport slave (
      input  req_valid, req_src_a, req_src_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flags, busy
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU datapath; unknown op codes yield a zero result (flags 0100).
module alu_arbiter_alu
   import alu_pkg::*;
(
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [2:0]  op,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   logic [32:0] sum;
   logic [31:0] b_eff;
   logic        carry_in;
   logic        arith;

   // Subtract is A + ~B + 1, so carry-out doubles as "no borrow"
   always_comb begin
      arith    = (op == ALU_ADD) || (op == ALU_SUB);
      carry_in = (op == ALU_SUB);
      b_eff    = (op == ALU_SUB) ? ~src_b : src_b;
      sum      = {1'b0, src_a} + {1'b0, b_eff} + {32'd0, carry_in};
      result   = '0;
      case (op)
         ALU_ADD, ALU_SUB: result = sum[31:0];
         ALU_AND:          result = src_a & src_b;
         ALU_OR:           result = src_a | src_b;
         ALU_XOR:          result = src_a ^ src_b;
         default:          result = '0;
      endcase
      flags        = '0;
      flags[FLG_N] = result[31];
      flags[FLG_Z] = (result == '0);
      flags[FLG_C] = arith & sum[32];
      flags[FLG_V] = arith & (src_a[31] == b_eff[31]) & (result[31] != src_a[31]);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters with a registered response slot.
// Optional per-requester stall counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     bus
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [NREQ*CNT_W-1:0] stall_cnt
`endif
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [31:0]      result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [NREQ-1:0]  grant;
   logic [NREQ-1:0]  req_ready;
   logic [PTR_W-1:0] grant_idx;
   logic             rsp_fire;
   logic             can_accept;
   logic             accept;
   logic [31:0]      alu_a, alu_b, alu_result;
   logic [2:0]       alu_op;
   logic [3:0]       alu_flags;

   function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] valid,
                                                input logic [PTR_W-1:0] ptr);
      logic [NREQ-1:0]  g;
      logic             found;
      logic [PTR_W-1:0] idx;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PTR_W'((int'(ptr) + i) % NREQ);
         if (!found && valid[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   // Only the current owner's rsp_ready can free the slot for a same-cycle accept
   always_comb begin
      rsp_fire   = (state_q == ARB_FULL) && |(rsp_valid_q & bus.rsp_ready);
      can_accept = (state_q == ARB_EMPTY) || rsp_fire;
      grant      = rr_grant(bus.req_valid, ptr_q);
      accept     = can_accept && |grant;
      req_ready  = can_accept ? grant : '0;
      grant_idx  = '0;
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_W'(i);
            alu_a     = bus.req_src_a[32*i +: 32];
            alu_b     = bus.req_src_b[32*i +: 32];
            alu_op    = bus.req_op[3*i +: 3];
         end
      end
   end

   alu_arbiter_alu u_alu (
      .src_a  (alu_a),
      .src_b  (alu_b),
      .op     (alu_op),
      .result (alu_result),
      .flags  (alu_flags)
   );

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      ptr_d       = ptr_q;
      result_d    = result_q;
      flags_d     = flags_q;
      if (accept) begin
         state_d     = ARB_FULL;
         rsp_valid_d = grant;
         ptr_d       = PTR_W'((int'(grant_idx) + 1) % NREQ);
         result_d    = alu_result;
         flags_d     = alu_flags;
      end else if (rsp_fire) begin
         state_d     = ARB_EMPTY;
         rsp_valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_EMPTY;
         rsp_valid_q <= '0;
         ptr_q       <= '0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         ptr_q       <= ptr_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_flags  = flags_q;
   assign bus.busy       = (state_q == ARB_FULL);

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] stall_q [NREQ];
   logic [CNT_W-1:0] stall_d [NREQ];

   // Counters saturate rather than wrap so a long stall never reads as a short one
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         stall_d[i] = stall_q[i];
         if (bus.req_valid[i] && !req_ready[i] && (stall_q[i] != '1)) begin
            stall_d[i] = stall_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) stall_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) stall_q[i] <= stall_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) stall_cnt[CNT_W*i +: CNT_W] = stall_q[i];
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
// Stall-counter checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ  = 2;
   localparam int CNT_W = 16;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   alu_arbiter_if #(.NREQ(NREQ)) bus ();
`ifdef ALU_ARB_STATS_EN
   logic [NREQ*CNT_W-1:0] stall_cnt;
`endif

   alu_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ALU_ARB_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state: one pending response slot plus a rotating priority start
   bit              m_pending;
   int              m_owner;
   int              m_ptr;
   logic [31:0]     m_res;
   logic [3:0]      m_flags;
   int              m_stall [NREQ];
   logic [NREQ-1:0] e_ready;
   logic [NREQ-1:0] e_rsp_valid;
   int              e_grant;
   bit              e_accept;
   bit              e_fire;

   function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op,
                                   output logic [31:0] r, output logic [3:0] f);
      longint sa, sb, ss;
      logic [32:0] wide;
      logic c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c  = 1'b0;
      v  = 1'b0;
      r  = '0;
      case (op)
         ALU_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[31:0];
            c = wide[32];
            ss = sa + sb;
            v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         ALU_SUB: begin
            r = a - b;
            c = (a >= b);
            ss = sa - sb;
            v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         default: begin
            f = 4'b0100;
            return;
         end
      endcase
      f = {r[31], (r == 32'd0), c, v};
   endfunction

   task automatic model_reset();
      m_pending = 0;
      m_owner   = 0;
      m_ptr     = 0;
      m_res     = '0;
      m_flags   = '0;
      for (int k = 0; k < NREQ; k++) m_stall[k] = 0;
   endtask

   task automatic model_expect();
      e_rsp_valid = m_pending ? (NREQ'(1) << m_owner) : '0;
      e_fire      = m_pending && bus.rsp_ready[m_owner];
      e_grant     = -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx = (m_ptr + k) % NREQ;
         if (e_grant < 0 && bus.req_valid[idx]) e_grant = idx;
      end
      e_accept = (!m_pending || e_fire) && (e_grant >= 0);
      e_ready  = e_accept ? (NREQ'(1) << e_grant) : '0;
   endtask

   task automatic model_advance();
      for (int k = 0; k < NREQ; k++) begin
         if (bus.req_valid[k] && !e_ready[k] && m_stall[k] < MAXC) m_stall[k]++;
      end
      if (e_accept) begin
         m_pending = 1;
         m_owner   = e_grant;
         ref_alu(bus.req_src_a[32*e_grant +: 32], bus.req_src_b[32*e_grant +: 32],
                 bus.req_op[3*e_grant +: 3], m_res, m_flags);
         m_ptr = (e_grant + 1) % NREQ;
      end else if (e_fire) begin
         m_pending = 0;
      end
   endtask

   task automatic cyc_begin();
      model_expect();
      @(negedge clk);
   endtask

   task automatic cyc_end();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic set_req(input int i, input bit v, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op);
      bus.req_valid[i]         = v;
      bus.req_src_a[32*i +: 32] = a;
      bus.req_src_b[32*i +: 32] = b;
      bus.req_op[3*i +: 3]      = op;
   endtask

   function automatic logic [2:0] pick_op();
      logic [2:0] ops [5];
      ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND; ops[3] = ALU_OR; ops[4] = ALU_XOR;
      return ops[$urandom_range(0, 4)];
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      bus.req_valid = '0;
      bus.req_src_a = '0;
      bus.req_src_b = '0;
      bus.req_op    = '0;
      bus.rsp_ready = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", bus.rsp_result); end
      checks++; if (bus.rsp_flags !== 4'd0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", bus.rsp_flags); end
`ifdef ALU_ARB_STATS_EN
      checks++; if (stall_cnt !== '0) begin errors++; $display("[TB] FAIL reset_stall: got %h expected 0", stall_cnt); end
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic_add();
      set_req(0, 1, 32'd5, 32'd3, ALU_ADD);
      cyc_begin();
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL add_ready: got %b expected 01", bus.req_ready); end
      cyc_end();
      set_req(0, 0, 32'd0, 32'd0, ALU_ADD);
      bus.rsp_ready = 2'b01;
      cyc_begin();
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL add_rsp_valid: got %b expected 01", bus.rsp_valid); end
      checks++; if (bus.rsp_result !== 32'h8) begin errors++; $display("[TB] FAIL add_result: got %h expected 8", bus.rsp_result); end
      checks++; if (bus.rsp_flags !== 4'b0000) begin errors++; $display("[TB] FAIL add_flags: got %b expected 0000", bus.rsp_flags); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL add_busy: got %b expected 1", bus.busy); end
      cyc_end();
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_alternate();
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
      bus.rsp_ready = 2'b11;
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < NREQ; k++) set_req(k, 1, $urandom, $urandom, pick_op());
         cyc_begin();
         checks++;
         if (bus.req_ready !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++; $display("[TB] FAIL alt_grant[%0d]: got %b expected %b", n, bus.req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
         end
         if (n > 0) begin
            checks++;
            if (bus.rsp_valid !== ((n % 2 == 0) ? 2'b10 : 2'b01)) begin
               errors++; $display("[TB] FAIL alt_rsp_valid[%0d]: got %b expected %b", n, bus.rsp_valid, (n % 2 == 0) ? 2'b10 : 2'b01);
            end
            checks++;
            if (bus.rsp_result !== m_res || bus.rsp_flags !== m_flags) begin
               errors++; $display("[TB] FAIL alt_data[%0d]: got %h/%b expected %h/%b", n, bus.rsp_result, bus.rsp_flags, m_res, m_flags);
            end
         end
         cyc_end();
      end
      for (int k = 0; k < NREQ; k++) set_req(k, 0, 32'd0, 32'd0, ALU_ADD);
      cyc_begin();
      checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL alt_last_rsp: got %b expected 10", bus.rsp_valid); end
      cyc_end();
   endtask

   task automatic test_sub_flags();
      bus.rsp_ready = 2'b10;
      set_req(1, 1, 32'h8000_0000, 32'h0000_0001, ALU_SUB);
      cyc_begin();
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL sub_ready: got %b expected 10", bus.req_ready); end
      cyc_end();
      set_req(1, 1, 32'd5, 32'd5, ALU_SUB);
      cyc_begin();
      checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL sub_rsp_valid: got %b expected 10", bus.rsp_valid); end
      checks++; if (bus.rsp_result !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL sub_ovf_result: got %h expected 7fffffff", bus.rsp_result); end
      checks++; if (bus.rsp_flags !== 4'b0011) begin errors++; $display("[TB] FAIL sub_ovf_flags: got %b expected 0011", bus.rsp_flags); end
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL sub_b2b_ready: got %b expected 10", bus.req_ready); end
      cyc_end();
      set_req(1, 0, 32'd0, 32'd0, ALU_ADD);
      cyc_begin();
      checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL sub_zero_result: got %h expected 0", bus.rsp_result); end
      checks++; if (bus.rsp_flags !== 4'b0110) begin errors++; $display("[TB] FAIL sub_zero_flags: got %b expected 0110", bus.rsp_flags); end
      cyc_end();
   endtask

   task automatic test_hold();
      int stall_before;
      bus.rsp_ready = 2'b00;
      set_req(0, 1, 32'h1234_5678, 32'h1111_1111, ALU_ADD);
      cyc_begin();
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL hold_first_ready: got %b expected 01", bus.req_ready); end
      cyc_end();
      stall_before = m_stall[1];
      set_req(0, 0, 32'd0, 32'd0, ALU_ADD);
      set_req(1, 1, 32'hA5A5_0000, 32'h0000_5A5A, ALU_OR);
      for (int n = 0; n < 4; n++) begin
         cyc_begin();
         checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL hold_ready[%0d]: got %b expected 00", n, bus.req_ready); end
         checks++;
         if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h2345_6789 || bus.rsp_flags !== 4'b0000) begin
            errors++; $display("[TB] FAIL hold_stable[%0d]: got %b %h %b expected 01 23456789 0000", n, bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
         end
         cyc_end();
      end
      bus.rsp_ready = 2'b01;
      cyc_begin();
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL hold_release_ready: got %b expected 10", bus.req_ready); end
      cyc_end();
      set_req(1, 0, 32'd0, 32'd0, ALU_ADD);
      bus.rsp_ready = 2'b10;
      cyc_begin();
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'hA5A5_5A5A || bus.rsp_flags !== 4'b1000) begin
         errors++; $display("[TB] FAIL hold_next_rsp: got %b %h %b expected 10 a5a55a5a 1000", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
      end
`ifdef ALU_ARB_STATS_EN
      checks++;
      if (stall_cnt[CNT_W +: CNT_W] !== CNT_W'(stall_before + 4)) begin
         errors++; $display("[TB] FAIL hold_stall_cnt: got %0d expected %0d", stall_cnt[CNT_W +: CNT_W], stall_before + 4);
      end
`endif
      cyc_end();
      bus.rsp_ready = 2'b00;
   endtask

   task automatic test_undef_xor();
      bus.rsp_ready = 2'b11;
      set_req(0, 1, $urandom, $urandom, 3'b101);
      cyc_begin();
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL undef_ready: got %b expected 01", bus.req_ready); end
      cyc_end();
      set_req(0, 0, 32'd0, 32'd0, ALU_ADD);
      set_req(1, 1, 32'hFFFF_0000, 32'hFFFF_FFFF, ALU_XOR);
      cyc_begin();
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd0 || bus.rsp_flags !== 4'b0100) begin
         errors++; $display("[TB] FAIL undef_rsp: got %b %h %b expected 01 00000000 0100", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
      end
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL xor_ready: got %b expected 10", bus.req_ready); end
      cyc_end();
      set_req(1, 0, 32'd0, 32'd0, ALU_ADD);
      cyc_begin();
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'h0000_FFFF || bus.rsp_flags !== 4'b0000) begin
         errors++; $display("[TB] FAIL xor_rsp: got %b %h %b expected 10 0000ffff 0000", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
      end
      cyc_end();
   endtask

   task automatic test_random();
      logic [NREQ-1:0] held;
      held = '0;
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!held[k]) set_req(k, ($urandom_range(0, 99) < 60), rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
         end
         bus.rsp_ready = NREQ'($urandom);
         cyc_begin();
         checks++; if (bus.req_ready !== e_ready) begin errors++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", n, bus.req_ready, e_ready); end
         checks++; if (bus.rsp_valid !== e_rsp_valid) begin errors++; $display("[TB] FAIL rnd_rsp_valid[%0d]: got %b expected %b", n, bus.rsp_valid, e_rsp_valid); end
         checks++; if (bus.busy !== m_pending) begin errors++; $display("[TB] FAIL rnd_busy[%0d]: got %b expected %b", n, bus.busy, m_pending); end
         if (m_pending) begin
            checks++;
            if (bus.rsp_result !== m_res || bus.rsp_flags !== m_flags) begin
               errors++; $display("[TB] FAIL rnd_data[%0d]: got %h/%b expected %h/%b", n, bus.rsp_result, bus.rsp_flags, m_res, m_flags);
            end
         end
`ifdef ALU_ARB_STATS_EN
         for (int k = 0; k < NREQ; k++) begin
            checks++;
            if (stall_cnt[CNT_W*k +: CNT_W] !== CNT_W'(m_stall[k])) begin
               errors++; $display("[TB] FAIL rnd_stall%0d[%0d]: got %0d expected %0d", k, n, stall_cnt[CNT_W*k +: CNT_W], m_stall[k]);
            end
         end
`endif
         held = bus.req_valid & ~e_ready;
         cyc_end();
      end
      for (int k = 0; k < NREQ; k++) set_req(k, 0, 32'd0, 32'd0, ALU_ADD);
      bus.rsp_ready = 2'b11;
      cyc_begin();
      cyc_end();
   endtask

   task automatic test_async_reset();
      bus.rsp_ready = 2'b00;
      set_req(0, 1, 32'd7, 32'd9, ALU_ADD);
      cyc_begin();
      cyc_end();
      set_req(0, 0, 32'd0, 32'd0, ALU_ADD);
      #2;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_busy: got %b expected 1", bus.busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL arst_rsp_valid: got %b expected 00", bus.rsp_valid); end
      checks++; if (bus.busy !== 1'b0 || bus.rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL arst_clear: got %b %h expected 0 00000000", bus.busy, bus.rsp_result); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      set_req(1, 1, 32'd100, 32'd1, ALU_SUB);
      bus.rsp_ready = 2'b10;
      cyc_begin();
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL arst_req1_ready: got %b expected 10", bus.req_ready); end
      cyc_end();
      set_req(1, 0, 32'd0, 32'd0, ALU_ADD);
      cyc_begin();
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'd99 || bus.rsp_flags !== 4'b0010) begin
         errors++; $display("[TB] FAIL arst_req1_rsp: got %b %h %b expected 10 00000063 0010", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
      end
      cyc_end();
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_alternate();
      test_sub_flags();
      test_hold();
      test_undef_xor();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
